// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core types and constants
// Imported by the fetch stage and Control_unit.
package core_pkg;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_VALID,
    FS_HALT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] GES_LT = 3'b001;
  localparam logic [2:0] GES_EQ = 3'b010;
  localparam logic [2:0] GES_GE = 3'b100;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - next-PC select with JALR LSB clear and alignment check
// Purely combinational; the fetch FSM decides when the result is committed.
module pc_next
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_src_i,
  input  logic            jalr_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  assign pc_plus4_o = pc_i + XLEN'(4);

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (pc_src_i) begin
      // JALR drops bit 0 of the computed target before use
      next_pc_o = jalr_src_i ? (alu_result_i & ~XLEN'(1)) : pc_target_i;
    end
  end

  assign misaligned_o = !word_aligned(next_pc_o[1:0]);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I instruction-fetch stage
// Owns the PC, runs one req/rvalid transaction at a time and holds Instr for execute.
module instr_fetch
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7_5,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            PCSrc,
  input  logic            JALR_Src,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic            misalign_fault,
  output logic            timeout_fault
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [7:0]      cnt_q;
  logic            req_q;
  logic            valid_q;
  logic            misalign_q;
  logic            timeout_q;

  logic [XLEN-1:0] next_pc_d;
  logic            misaligned_d;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i         (pc_q),
    .pc_src_i     (PCSrc),
    .jalr_src_i   (JALR_Src),
    .pc_target_i  (PCTarget),
    .alu_result_i (ALUResult),
    .pc_plus4_o   (PCPlus4),
    .next_pc_o    (next_pc_d),
    .misaligned_o (misaligned_d)
  );

  // Outputs are registered alongside the state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          state_q <= FS_REQ;
          req_q   <= 1'b1;
        end
        FS_REQ: begin
          state_q <= FS_WAIT;
          req_q   <= 1'b0;
          cnt_q   <= '0;
        end
        FS_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= FS_VALID;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= FS_HALT;
          end
        end
        FS_VALID: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            if (misaligned_d) begin
              misalign_q <= 1'b1;
              state_q    <= FS_HALT;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= FS_REQ;
            end
          end
        end
        FS_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= FS_HALT;
        end
      endcase
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign PC             = pc_q;
  assign Instr          = instr_q;
  assign op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7_5       = instr_q[30];
  assign instr_valid    = valid_q;
  assign misalign_fault = misalign_q;
  assign timeout_fault  = timeout_q;

endmodule
